// File: rtl/mem.sv
// MEM stage of the five-stage MIPS pipeline: EX/MEM register with stall/flush,
// load-data extraction from the synchronous SRAM, exception commit and mtc0 commit.
module mem #(
  parameter int EX_TO_MEM_WD = 229,
  parameter int MEM_TO_WB_WD = 136,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_fwd,
  output logic                    exc_req,
  output logic [4:0]              exc_code,
  output logic [31:0]             exc_epc,
  output logic [31:0]             exc_badvaddr,
  output logic                    exc_bd,
  output logic                    cp0_we,
  output logic [4:0]              cp0_waddr,
  output logic [2:0]              cp0_wsel,
  output logic [31:0]             cp0_wdata
);

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [4:0]  excepttype;
    logic        is_in_delayslot;
    logic [31:0] pc;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic [3:0]  data_ram_sel;
    logic        inst_lb;
    logic        inst_lbu;
    logic        inst_lh;
    logic        inst_lhu;
    logic [31:0] hi_wdata;
    logic        hi_we;
    logic [31:0] lo_wdata;
    logic        lo_we;
    logic [3:0]  data_ram_wen;
    logic        data_ram_en;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  ex_mem_t ex_mem_d, ex_mem_q;

  // Stop on 3 with NoStop on 4 means WB drains while EX holds: insert a bubble.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (flush)                      ex_mem_d = '0;
    else if (stall[3] && !stall[4]) ex_mem_d = '0;
    else if (!stall[3])             ex_mem_d = ex_mem_t'(ex_to_mem_bus);
  end

  always_ff @(posedge clk) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[2:0], ex_mem_q.data_ram_wen, ex_mem_q.data_ram_en};

  logic        mem_valid;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_ok;
  logic [31:0] rf_wdata;

  assign mem_valid = (ex_mem_q.pc != 32'd0);

  always_comb begin
    ld_byte  = 8'd0;
    ld_half  = 16'd0;
    ld_ok    = 1'b1;
    rf_wdata = ex_mem_q.ex_result;
    if (ex_mem_q.sel_rf_res) begin
      if (ex_mem_q.inst_lb || ex_mem_q.inst_lbu) begin
        unique case (ex_mem_q.data_ram_sel)
          4'b0001: ld_byte = data_sram_rdata[7:0];
          4'b0010: ld_byte = data_sram_rdata[15:8];
          4'b0100: ld_byte = data_sram_rdata[23:16];
          4'b1000: ld_byte = data_sram_rdata[31:24];
          default: ld_ok   = 1'b0;
        endcase
        rf_wdata = ld_ok ? {{24{ex_mem_q.inst_lb & ld_byte[7]}}, ld_byte} : 32'd0;
      end else if (ex_mem_q.inst_lh || ex_mem_q.inst_lhu) begin
        unique case (ex_mem_q.data_ram_sel)
          4'b0011: ld_half = data_sram_rdata[15:0];
          4'b1100: ld_half = data_sram_rdata[31:16];
          default: ld_ok   = 1'b0;
        endcase
        rf_wdata = ld_ok ? {{16{ex_mem_q.inst_lh & ld_half[15]}}, ld_half} : 32'd0;
      end else begin
        rf_wdata = data_sram_rdata;
      end
    end
  end

  // A faulting instruction keeps its data fields but loses every write enable.
  logic rf_we_g, hi_we_g, lo_we_g;

  always_comb begin
    mem_to_wb_bus = '0;
    mem_fwd       = '0;
    exc_req       = 1'b0;
    exc_code      = 5'd0;
    exc_epc       = 32'd0;
    exc_badvaddr  = 32'd0;
    exc_bd        = 1'b0;
    cp0_we        = 1'b0;
    cp0_waddr     = 5'd0;
    cp0_wsel      = 3'd0;
    cp0_wdata     = 32'd0;
    rf_we_g       = 1'b0;
    hi_we_g       = 1'b0;
    lo_we_g       = 1'b0;
    if (mem_valid) begin
      exc_req = (ex_mem_q.excepttype != 5'd0);
      if (exc_req) begin
        exc_code     = ex_mem_q.excepttype;
        exc_epc      = ex_mem_q.is_in_delayslot ? ex_mem_q.pc - 32'd4 : ex_mem_q.pc;
        exc_badvaddr = ex_mem_q.badvaddr;
        exc_bd       = ex_mem_q.is_in_delayslot;
      end
      rf_we_g       = ex_mem_q.rf_we & ~exc_req;
      hi_we_g       = ex_mem_q.hi_we & ~exc_req;
      lo_we_g       = ex_mem_q.lo_we & ~exc_req;
      cp0_we        = ex_mem_q.cp0_we & ~exc_req;
      cp0_waddr     = ex_mem_q.cp0_addr;
      cp0_wsel      = ex_mem_q.cp0_sel;
      cp0_wdata     = ex_mem_q.cp0_wdata;
      mem_to_wb_bus = {ex_mem_q.pc, hi_we_g, ex_mem_q.hi_wdata, lo_we_g, ex_mem_q.lo_wdata,
                       rf_we_g, ex_mem_q.rf_waddr, rf_wdata};
      mem_fwd       = {rf_we_g, ex_mem_q.rf_waddr, rf_wdata};
    end
  end

endmodule

// File: tb/tb_mem.sv
// Randomized and directed bench for the MEM stage against a field-level reference model.
module tb_mem;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [4:0]  excepttype;
    logic        is_in_delayslot;
    logic [31:0] pc;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic [3:0]  data_ram_sel;
    logic        inst_lb;
    logic        inst_lbu;
    logic        inst_lh;
    logic        inst_lhu;
    logic [31:0] hi_wdata;
    logic        hi_we;
    logic [31:0] lo_wdata;
    logic        lo_we;
    logic [3:0]  data_ram_wen;
    logic        data_ram_en;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_t;

  localparam logic [4:0] ADEL = 5'h04;
  localparam logic [4:0] OV   = 5'h0c;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [5:0]    stall;
  ex_t           ex_b;
  logic [228:0]  ex_to_mem_bus;
  logic [31:0]   data_sram_rdata;
  logic [135:0]  mem_to_wb_bus;
  logic [37:0]   mem_fwd;
  logic          exc_req, exc_bd, cp0_we;
  logic [4:0]    exc_code, cp0_waddr;
  logic [31:0]   exc_epc, exc_badvaddr, cp0_wdata;
  logic [2:0]    cp0_wsel;
  logic [285:0]  obs_all;

  int   checks = 0;
  int   failures = 0;
  ex_t  model_q = '0;

  assign ex_to_mem_bus = ex_b;
  assign obs_all = {mem_to_wb_bus, mem_fwd, exc_req, exc_code, exc_epc, exc_badvaddr, exc_bd,
                    cp0_we, cp0_waddr, cp0_wsel, cp0_wdata};

  always #5 clk = ~clk;

  mem dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_to_mem_bus(ex_to_mem_bus), .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_fwd(mem_fwd),
    .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_bd(exc_bd),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wdata(cp0_wdata)
  );

  function automatic ex_t next_reg(ex_t cur, ex_t in, logic [5:0] st, logic fl, logic rs);
    if (rs || fl)             return '0;
    if (st[3] && !st[4])      return '0;
    if (!st[3])               return in;
    return cur;
  endfunction

  // Load value from lane arithmetic: which byte/half the select picks, shifted down.
  function automatic logic [31:0] load_value(ex_t r, logic [31:0] rd);
    int unsigned v;
    int idx;
    if (!r.sel_rf_res) return r.ex_result;
    if (r.inst_lb || r.inst_lbu) begin
      idx = -1;
      for (int k = 0; k < 4; k++) if (r.data_ram_sel == 4'(1 << k)) idx = k;
      if (idx < 0) return 32'd0;
      v = (rd >> (8 * idx)) & 32'hFF;
      if (r.inst_lb && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (r.inst_lh || r.inst_lhu) begin
      if (r.data_ram_sel == 4'b0011)      v = rd % 65536;
      else if (r.data_ram_sel == 4'b1100) v = rd / 65536;
      else return 32'd0;
      if (r.inst_lh && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  function automatic logic [285:0] model_out(ex_t r, logic [31:0] rd);
    logic        exc;
    logic [31:0] w;
    logic [135:0] wb;
    logic [37:0]  fwd;
    logic [70:0]  ex_rec;
    logic [40:0]  c0;
    if (r.pc == 32'd0) return '0;
    exc    = (r.excepttype != 0);
    w      = load_value(r, rd);
    wb     = {r.pc, r.hi_we && !exc, r.hi_wdata, r.lo_we && !exc, r.lo_wdata,
              r.rf_we && !exc, r.rf_waddr, w};
    fwd    = {r.rf_we && !exc, r.rf_waddr, w};
    ex_rec = exc ? {1'b1, r.excepttype, (r.is_in_delayslot ? r.pc - 32'd4 : r.pc),
                    r.badvaddr, r.is_in_delayslot} : '0;
    c0     = {r.cp0_we && !exc, r.cp0_addr, r.cp0_sel, r.cp0_wdata};
    return {wb, fwd, ex_rec, c0};
  endfunction

  task automatic cycle();
    model_q = next_reg(model_q, ex_b, stall, flush, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = '0; data_sram_rdata = 32'hDEAD_BEEF;
    ex_b = '0; ex_b.pc = 32'hBFC0_0000; ex_b.rf_we = 1'b1; ex_b.excepttype = OV;
    cycle(); cycle();
    rst = 1'b0; #1;
    checks++;
    if (obs_all !== '0) begin failures++; $display("FAIL reset_all got=%h exp=0", obs_all); end
    checks++;
    if (exc_req !== 1'b0 || cp0_we !== 1'b0) begin
      failures++; $display("FAIL reset_exc got=%b/%b exp=0/0", exc_req, cp0_we);
    end
  endtask

  task automatic test_load();
    logic [31:0] exp_w [4];
    ex_t b;
    exp_w[0] = 32'hFFFF_FF80; exp_w[1] = 32'h0000_0080;
    exp_w[2] = 32'hFFFF_8001; exp_w[3] = 32'h0000_8001;
    for (int k = 0; k < 4; k++) begin
      b = '0;
      b.pc = 32'hBFC0_0010 + 32'(k * 4); b.sel_rf_res = 1'b1; b.rf_we = 1'b1;
      b.rf_waddr = 5'd9; b.ex_result = 32'h8000_0002; b.data_ram_en = 1'b1;
      b.inst_lb = (k == 0); b.inst_lbu = (k == 1); b.inst_lh = (k == 2); b.inst_lhu = (k == 3);
      b.data_ram_sel = (k < 2) ? 4'b0100 : 4'b1100;
      ex_b = b; stall = '0;
      cycle();
      ex_b = '0;
      data_sram_rdata = (k < 2) ? 32'h1280_3456 : 32'h8001_0000;
      #1;
      checks++;
      if (mem_to_wb_bus[37:0] !== {1'b1, 5'd9, exp_w[k]}) begin
        failures++; $display("FAIL load_%0d got=%h exp=%h", k, mem_to_wb_bus[37:0], {1'b1, 5'd9, exp_w[k]});
      end
      checks++;
      if (obs_all !== model_out(model_q, data_sram_rdata)) begin
        failures++; $display("FAIL load_model_%0d got=%h exp=%h", k, obs_all, model_out(model_q, data_sram_rdata));
      end
    end
  endtask

  task automatic test_exception();
    ex_t b;
    b = '0;
    b.pc = 32'hBFC0_0100; b.is_in_delayslot = 1'b1; b.badvaddr = 32'h1001;
    b.excepttype = ADEL; b.rf_we = 1'b1; b.rf_waddr = 5'd3; b.hi_we = 1'b1; b.lo_we = 1'b1;
    ex_b = b; stall = '0;
    cycle();
    checks++;
    if ({exc_req, exc_code, exc_epc, exc_badvaddr, exc_bd} !== {1'b1, ADEL, 32'hBFC0_00FC, 32'h1001, 1'b1}) begin
      failures++; $display("FAIL exc_record got=%b %h %h %h %b exp=1 04 bfc000fc 00001001 1",
                           exc_req, exc_code, exc_epc, exc_badvaddr, exc_bd);
    end
    checks++;
    if (mem_to_wb_bus[37] !== 1'b0 || mem_fwd[37] !== 1'b0 || mem_to_wb_bus[103] !== 1'b0 || mem_to_wb_bus[70] !== 1'b0) begin
      failures++; $display("FAIL exc_we_gate got=%b%b%b%b exp=0000",
                           mem_to_wb_bus[37], mem_fwd[37], mem_to_wb_bus[103], mem_to_wb_bus[70]);
    end
    flush = 1'b1;
    ex_b.excepttype = 5'd0; ex_b.pc = 32'hBFC0_0104;
    cycle();
    flush = 1'b0;
    checks++;
    if (obs_all !== '0) begin failures++; $display("FAIL exc_flush got=%h exp=0", obs_all); end
  endtask

  task automatic test_mtc0();
    ex_t b;
    b = '0;
    b.pc = 32'hBFC0_0200; b.cp0_we = 1'b1; b.cp0_addr = 5'd12; b.cp0_wdata = 32'h0040_FF01;
    ex_b = b; stall = '0;
    cycle();
    ex_b = '0;
    checks++;
    if ({cp0_we, cp0_waddr, cp0_wsel, cp0_wdata} !== {1'b1, 5'd12, 3'd0, 32'h0040_FF01}) begin
      failures++; $display("FAIL mtc0_commit got=%b %0d %0d %h exp=1 12 0 0040ff01", cp0_we, cp0_waddr, cp0_wsel, cp0_wdata);
    end
    cycle();
    checks++;
    if (cp0_we !== 1'b0) begin failures++; $display("FAIL mtc0_one_cycle got=%b exp=0", cp0_we); end
    b.excepttype = OV;
    ex_b = b;
    cycle();
    ex_b = '0;
    checks++;
    if (cp0_we !== 1'b0 || exc_req !== 1'b1 || exc_code !== OV) begin
      failures++; $display("FAIL mtc0_ov got=%b/%b/%h exp=0/1/0c", cp0_we, exc_req, exc_code);
    end
  endtask

  task automatic test_stall();
    ex_t a;
    logic [285:0] snap;
    a = '0;
    a.pc = 32'hBFC0_0300; a.sel_rf_res = 1'b1; a.rf_we = 1'b1; a.rf_waddr = 5'd7;
    a.inst_lh = 1'b1; a.data_ram_sel = 4'b0011;
    ex_b = a; stall = 6'b000111;
    cycle();
    data_sram_rdata = 32'h0000_9ABC; #1;
    checks++;
    if (mem_fwd !== {1'b1, 5'd7, 32'hFFFF_9ABC}) begin
      failures++; $display("FAIL stall_load got=%h exp=%h", mem_fwd, {1'b1, 5'd7, 32'hFFFF_9ABC});
    end
    snap = obs_all;
    ex_b.pc = 32'hBFC0_0304; ex_b.rf_waddr = 5'd8;
    stall = 6'b011111;
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++;
      if (obs_all !== snap || obs_all !== model_out(model_q, data_sram_rdata)) begin
        failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", n, obs_all, snap);
      end
    end
    stall = 6'b001111;
    cycle();
    checks++;
    if (obs_all !== '0) begin failures++; $display("FAIL stall_bubble got=%h exp=0", obs_all); end
  endtask

  task automatic test_flush_rst();
    ex_t a;
    a = '0;
    a.pc = 32'hBFC0_0400; a.rf_we = 1'b1; a.rf_waddr = 5'd2; a.ex_result = 32'h55;
    a.sel_rf_res = 1'b1; a.inst_lbu = 1'b1; a.data_ram_sel = 4'b1000;
    ex_b = a; stall = '0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (obs_all !== '0) begin failures++; $display("FAIL flush_vs_load got=%h exp=0", obs_all); end
    cycle();
    data_sram_rdata = 32'hA500_0000; #1;
    checks++;
    if (mem_fwd !== {1'b1, 5'd2, 32'h0000_00A5}) begin
      failures++; $display("FAIL rst_preload got=%h exp=%h", mem_fwd, {1'b1, 5'd2, 32'h0000_00A5});
    end
    stall = 6'b011111; rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (obs_all !== '0) begin failures++; $display("FAIL rst_in_hold got=%h exp=0", obs_all); end
    stall = '0;
  endtask

  task automatic test_random();
    logic [255:0] rnd;
    logic [5:0]   pats [5];
    ex_t b;
    logic hold;
    pats[0] = 6'b000000; pats[1] = 6'b000111; pats[2] = 6'b011111;
    pats[3] = 6'b001111; pats[4] = 6'b111111;
    for (int it = 0; it < 400; it++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom();
      b = ex_t'(rnd[228:0]);
      {b.inst_lb, b.inst_lbu, b.inst_lh, b.inst_lhu} = 4'd0;
      case ($urandom_range(0, 4))
        0: b.inst_lb  = 1'b1;
        1: b.inst_lbu = 1'b1;
        2: b.inst_lh  = 1'b1;
        3: b.inst_lhu = 1'b1;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        if (b.inst_lh || b.inst_lhu) b.data_ram_sel = $urandom_range(0, 1) ? 4'b0011 : 4'b1100;
        else                         b.data_ram_sel = 4'(1 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) != 0) b.excepttype = 5'd0;
      if ($urandom_range(0, 9) == 0) b.pc = 32'd0;
      ex_b  = b;
      stall = pats[$urandom_range(0, 4)];
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 31) == 0);
      hold  = stall[3] && stall[4] && !flush && !rst;
      cycle();
      flush = 1'b0; rst = 1'b0;
      if (!hold) data_sram_rdata = $urandom();
      #1;
      checks++;
      if (obs_all !== model_out(model_q, data_sram_rdata)) begin
        failures++; $display("FAIL random_%0d got=%h exp=%h", it, obs_all, model_out(model_q, data_sram_rdata));
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; ex_b = '0; data_sram_rdata = '0;
    test_reset();
    test_load();
    test_exception();
    test_mtc0();
    test_stall();
    test_flush_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
